spi_shifter: RTL
================

Name: spi_shifter

Overview:
- Data path stage directly downstream of the baud rate generator in the APB SPI master.
- Loads a parallel byte from the APB data register and serialises it onto MOSI.
- Deserialises MISO into a parallel byte that the APB side reads back.
- Transmit and capture timing come from the generator's one-PCLK flag pulses, selected by CPOL/CPHA.

Parameters:
DATA_W, 8, transfer width in bits; counters are $clog2(DATA_W)+1 bits wide.

Ports:
PCLK  input  1  system clock
PRESETn  input  1  reset, asynchronous, active-low
send_data  input  1  one-cycle start request from the controller
data_mosi  input  DATA_W  byte to transmit, sampled on accepted send_data
lsbfe  input  1  1 = LSB first, 0 = MSB first; sampled on accepted send_data
cpol  input  1  clock polarity (flag selection only)
cpha  input  1  clock phase
ss  input  1  slave select, active-low; high aborts
flag_low  input  1  generator sample pulse, CPOL==CPHA modes
flag_high  input  1  generator sample pulse, CPOL!=CPHA modes
flags_low  input  1  generator shift pulse, CPOL==CPHA modes
flags_high  input  1  generator shift pulse, CPOL!=CPHA modes
miso  input  1  serial data in
mosi  output  1  serial data out, registered
data_miso  output  DATA_W  last completed received byte
receive_data  output  1  one-cycle completion pulse
busy  output  1  transfer in progress

Behaviour:
- Reset values: mosi=0, data_miso=0, receive_data=0, busy=0, state=IDLE, tx_cnt=0, rx_cnt=0, internal shift registers 0.
- Event selection:
  - shift_evt = (cpol==cpha) ? flags_low : flags_high.
  - sample_evt = (cpol==cpha) ? flag_low : flag_high.
  - Both events are gated by ~ss.
- bit(i) = lsbfe_q ? tx_reg[i] : tx_reg[DATA_W-1-i]. Received bit i is written to the same mirrored index.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - On send_data=1 with ss=0: tx_reg<=data_mosi, lsbfe_q<=lsbfe, rx_cnt<=0, busy<=1, go ACTIVE.
  - CPHA=0 start: mosi<=bit(0), tx_cnt<=1.
  - CPHA=1 start: mosi unchanged (0), tx_cnt<=0.
  - send_data with ss=1 is ignored.
- ACTIVE:
  - A sample_evt is accepted when tx_cnt>rx_cnt and rx_cnt<DATA_W. Accepting it stores miso at bit index rx_cnt and increments rx_cnt.
  - A shift_evt is accepted when tx_cnt==rx_cnt and tx_cnt<DATA_W. Accepting it sets mosi<=bit(tx_cnt) and increments tx_cnt.
  - All other events are ignored. This covers the CPHA=0 shift pulse before the first sample and the trailing shift after the last bit.
  - If sample_evt and shift_evt occur in the same cycle, sample wins and shift is ignored. Both conditions use pre-cycle counter values.
  - When an accepted sample makes rx_cnt==DATA_W, go DONE.
  - ss=1 in any cycle aborts: go IDLE, busy<=0, mosi<=0, no receive_data, data_miso unchanged.
- DONE (one cycle):
  - data_miso<=assembled rx byte, including the final bit.
  - receive_data=1 for exactly this cycle.
  - busy<=0, mosi<=0, go IDLE.
- send_data is ignored while in ACTIVE or DONE.
- Latency:
  - busy and the CPHA=0 first bit are valid the cycle after send_data.
  - receive_data is asserted the cycle after the DATA_W-th accepted sample_evt.
  - data_miso is valid in that same cycle and held until the next completion.
- Asynchronous reset mid-transfer returns everything to reset values immediately. No receive_data.
- cpol, cpha and DATA_W changes during ACTIVE are undefined usage. The bench does not drive them.

Test Plan:
- Mode 0, MSB first, data_mosi=0xA5, miso looped from mosi, 8 flags_low/flag_low pairs -> mosi sequence 1,0,1,0,0,1,0,1; receive_data single pulse; data_miso=0xA5; busy falls with the pulse.
- Mode 1 (cpol=0, cpha=1), lsbfe=1, data_mosi=0x3C, miso=1 constant -> first mosi bit appears only after the first flags_high; mosi sequence 0,0,1,1,1,1,0,0; data_miso=0xFF.
- Mode 0: inject flags_low before the first flag_low and one extra flags_low after the 8th sample -> both ignored; tx and rx counts end at 8; exactly one receive_data.
- Abort: raise ss after 4 samples of a 0x5A transfer -> state IDLE, mosi=0, busy=0, no receive_data, data_miso keeps its prior value 0xA5.
- Reset: drop PRESETn mid-transfer, then restart with 0x81 in mode 3 (cpol=1, cpha=1, CPOL==CPHA flags), loopback -> all outputs 0 during reset; data_miso=0x81 after completion.
- Same-cycle sample_evt and shift_evt, plus send_data while busy -> sample taken, shift dropped; new data_mosi=0xFF not loaded; in-flight byte completes unchanged.

Source files
------------

// File: rtl/spi_shifter_if.sv
// Controller-side bundle of the SPI shifter: start request, transmit byte,
// bit order, mode bits, slave select, and the receive/status path back.
interface spi_shifter_if #(
   parameter int DATA_W = 8
);
   logic              send_data;
   logic [DATA_W-1:0] data_mosi;
   logic              lsbfe;
   logic              cpol;
   logic              cpha;
   logic              ss;
   logic [DATA_W-1:0] data_miso;
   logic              receive_data;
   logic              busy;

   // Controller side: issues transfers, observes completion.
   modport master (
      output send_data, data_mosi, lsbfe, cpol, cpha, ss,
      input  data_miso, receive_data, busy
   );

   // Shifter side: accepts transfers, reports completion.
   modport slave (
      input  send_data, data_mosi, lsbfe, cpol, cpha, ss,
      output data_miso, receive_data, busy
   );
endinterface

// File: rtl/spi_shifter.sv
// SPI shift stage: serialises a loaded byte onto mosi and assembles miso into
// a parallel byte, paced by the baud generator's one-PCLK sample/shift pulses.
module spi_shifter #(
   parameter int DATA_W = 8
) (
   input  logic         PCLK,
   input  logic         PRESETn,
   spi_shifter_if.slave bus,
   input  logic         flag_low,
   input  logic         flag_high,
   input  logic         flags_low,
   input  logic         flags_high,
   input  logic         miso,
   output logic         mosi
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] tx_reg;
   logic [DATA_W-1:0] rx_reg;
   logic [DATA_W-1:0] rx_nxt;
   logic              lsbfe_q;
   logic [CNT_W-1:0]  tx_cnt;
   logic [CNT_W-1:0]  rx_cnt;
   logic              mode_eq;
   logic              shift_evt;
   logic              sample_evt;
   logic              start;
   logic              sample_ok;
   logic              shift_ok;
   logic              last_sample;

   // Position of transfer bit 'cnt' inside the byte, honouring bit order.
   function automatic logic [IDX_W-1:0] bit_idx(input logic [CNT_W-1:0] cnt,
                                                input logic             lsb);
      logic [CNT_W-1:0] pos;
      pos = lsb ? cnt : (CNT_W'(DATA_W - 1) - cnt);
      return pos[IDX_W-1:0];
   endfunction

   // Event selection and acceptance; both use the counters as they stand
   // at the start of the cycle, and a sample always beats a shift.
   always_comb begin
      mode_eq     = (bus.cpol == bus.cpha);
      shift_evt   = ~bus.ss & (mode_eq ? flags_low : flags_high);
      sample_evt  = ~bus.ss & (mode_eq ? flag_low  : flag_high);
      start       = (state == IDLE) & bus.send_data & ~bus.ss;
      sample_ok   = (state == ACTIVE) & sample_evt & (tx_cnt > rx_cnt)
                  & (rx_cnt < CNT_W'(DATA_W));
      shift_ok    = (state == ACTIVE) & shift_evt & ~sample_ok
                  & (tx_cnt == rx_cnt) & (tx_cnt < CNT_W'(DATA_W));
      last_sample = sample_ok & (rx_cnt == CNT_W'(DATA_W - 1));
      rx_nxt      = rx_reg;
      rx_nxt[bit_idx(rx_cnt, lsbfe_q)] = miso;
   end

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic: slave select high drops any transfer in flight.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACTIVE;
         ACTIVE: begin
            if (bus.ss)           state_nxt = IDLE;
            else if (last_sample) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from state: busy drops as the completion pulse rises.
   always_comb begin
      bus.busy         = (state == ACTIVE);
      bus.receive_data = (state == DONE);
   end

   // Shift datapath: load on start, shift/sample while active, publish on completion.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_reg        <= '0;
         rx_reg        <= '0;
         lsbfe_q       <= 1'b0;
         tx_cnt        <= '0;
         rx_cnt        <= '0;
         mosi          <= 1'b0;
         bus.data_miso <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tx_reg  <= bus.data_mosi;
                  lsbfe_q <= bus.lsbfe;
                  rx_reg  <= '0;
                  rx_cnt  <= '0;
                  if (bus.cpha) begin
                     tx_cnt <= '0;
                  end else begin
                     // Phase 0 presents the first bit before the first sample edge.
                     mosi   <= bus.lsbfe ? bus.data_mosi[0] : bus.data_mosi[DATA_W-1];
                     tx_cnt <= CNT_W'(1);
                  end
               end
            end
            ACTIVE: begin
               if (bus.ss) begin
                  mosi <= 1'b0;
               end else if (sample_ok) begin
                  rx_reg <= rx_nxt;
                  rx_cnt <= rx_cnt + CNT_W'(1);
                  if (last_sample) bus.data_miso <= rx_nxt;
               end else if (shift_ok) begin
                  mosi   <= tx_reg[bit_idx(tx_cnt, lsbfe_q)];
                  tx_cnt <= tx_cnt + CNT_W'(1);
               end
            end
            DONE:    mosi <= 1'b0;
            default: mosi <= 1'b0;
         endcase
      end
   end
endmodule
